// File: rtl/scoreboard_hazard_unit_if.sv
// scoreboard_hazard_unit_if: issue, lookahead, dispatch and commit signals of the register scoreboard
interface scoreboard_hazard_unit_if #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_REGS    = 64,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int UUID_BITS   = 44
);
    localparam int NW_BITS = NUM_WARPS > 1 ? $clog2(NUM_WARPS) : 1;
    localparam int NR_BITS = $clog2(NUM_REGS);
    logic                   sb_valid;
    logic                   sb_ready;
    logic [UUID_BITS-1:0]   sb_uuid;
    logic [NW_BITS-1:0]     sb_wid;
    logic [NUM_THREADS-1:0] sb_tmask;
    logic [XLEN-1:0]        sb_PC;
    logic                   sb_wb;
    logic [NR_BITS-1:0]     sb_rd;
    logic [NR_BITS-1:0]     sb_rd_n;
    logic [NR_BITS-1:0]     sb_rs1_n;
    logic [NR_BITS-1:0]     sb_rs2_n;
    logic [NR_BITS-1:0]     sb_rs3_n;
    logic [NW_BITS-1:0]     sb_wid_n;
    logic                   dsp_valid;
    logic                   dsp_ready;
    logic [UUID_BITS-1:0]   dsp_uuid;
    logic [NW_BITS-1:0]     dsp_wid;
    logic [NUM_THREADS-1:0] dsp_tmask;
    logic [XLEN-1:0]        dsp_PC;
    logic                   dsp_wb;
    logic [NR_BITS-1:0]     dsp_rd;
    logic                   cmt_valid;
    logic [NW_BITS-1:0]     cmt_wid;
    logic [NR_BITS-1:0]     cmt_rd;
    logic                   cmt_wb;
    logic                   cmt_eop;
    logic [31:0]            perf_stalls;
    modport master (
        output sb_valid, sb_uuid, sb_wid, sb_tmask, sb_PC, sb_wb, sb_rd,
        output sb_rd_n, sb_rs1_n, sb_rs2_n, sb_rs3_n, sb_wid_n,
        input  sb_ready,
        input  dsp_valid, dsp_uuid, dsp_wid, dsp_tmask, dsp_PC, dsp_wb, dsp_rd,
        output dsp_ready,
        output cmt_valid, cmt_wid, cmt_rd, cmt_wb, cmt_eop,
        input  perf_stalls
    );
    modport slave (
        input  sb_valid, sb_uuid, sb_wid, sb_tmask, sb_PC, sb_wb, sb_rd,
        input  sb_rd_n, sb_rs1_n, sb_rs2_n, sb_rs3_n, sb_wid_n,
        output sb_ready,
        output dsp_valid, dsp_uuid, dsp_wid, dsp_tmask, dsp_PC, dsp_wb, dsp_rd,
        input  dsp_ready,
        input  cmt_valid, cmt_wid, cmt_rd, cmt_wb, cmt_eop,
        output perf_stalls
    );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit: per-warp register scoreboard holding RAW/WAW hazards in front of dispatch
module scoreboard_hazard_unit #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_REGS    = 64,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int UUID_BITS   = 44
) (
    input logic clk,
    input logic reset,
    scoreboard_hazard_unit_if.slave bus
);
    localparam int NW_BITS = NUM_WARPS > 1 ? $clog2(NUM_WARPS) : 1;
    localparam int NR_BITS = $clog2(NUM_REGS);
    logic [NUM_REGS-1:0] inuse [NUM_WARPS];
    logic [NUM_REGS-1:0] inuse_n [NUM_WARPS];
    logic [NR_BITS-1:0]  op_reg [4];
    logic [NR_BITS-1:0]  reg_n [4];
    logic [NW_BITS-1:0]  op_wid;
    logic [3:0]          op_busy, busy, busy_n;
    logic                rel, rsv, hazard, out_free, fire;
    assign rel      = bus.cmt_valid & bus.cmt_wb & bus.cmt_eop & (bus.cmt_rd != '0);
    assign hazard   = bus.sb_valid & |busy;
    assign out_free = ~bus.dsp_valid | bus.dsp_ready;
    assign bus.sb_ready = ~reset & ~hazard & out_free;
    assign fire     = bus.sb_valid & bus.sb_ready;
    assign rsv      = fire & bus.sb_wb & (bus.sb_rd != '0);
    always_comb begin
        reg_n[0] = bus.sb_rd_n;
        reg_n[1] = bus.sb_rs1_n;
        reg_n[2] = bus.sb_rs2_n;
        reg_n[3] = bus.sb_rs3_n;
    end
    // a commit landing this cycle unblocks the waiting instruction immediately
    always_comb begin
        busy = '0;
        for (int i = 0; i < 4; i++)
            busy[i] = op_busy[i] & ~(rel & (bus.cmt_wid == op_wid) & (bus.cmt_rd == op_reg[i]));
    end
    // release first so a same-cycle reserve of the same register wins
    always_comb begin
        inuse_n = inuse;
        busy_n  = '0;
        if (rel) inuse_n[bus.cmt_wid][bus.cmt_rd] = 1'b0;
        if (rsv) inuse_n[bus.sb_wid][bus.sb_rd] = 1'b1;
        for (int i = 0; i < 4; i++)
            busy_n[i] = inuse_n[bus.sb_wid_n][reg_n[i]];
    end
    always_ff @(posedge clk) begin
        op_reg <= reg_n;
        op_wid <= bus.sb_wid_n;
        if (reset) begin
            inuse           <= '{default: '0};
            op_busy         <= '0;
            bus.perf_stalls <= '0;
            bus.dsp_valid   <= 1'b0;
            bus.dsp_uuid    <= '0;
            bus.dsp_wid     <= '0;
            bus.dsp_tmask   <= '0;
            bus.dsp_PC      <= '0;
            bus.dsp_wb      <= 1'b0;
            bus.dsp_rd      <= '0;
        end else begin
            inuse   <= inuse_n;
            op_busy <= busy_n;
            if (hazard && !(&bus.perf_stalls)) bus.perf_stalls <= bus.perf_stalls + 32'd1;
            if (fire) begin
                bus.dsp_valid <= 1'b1;
                bus.dsp_uuid  <= bus.sb_uuid;
                bus.dsp_wid   <= bus.sb_wid;
                bus.dsp_tmask <= bus.sb_tmask;
                bus.dsp_PC    <= bus.sb_PC;
                bus.dsp_wb    <= bus.sb_wb;
                bus.dsp_rd    <= bus.sb_rd;
            end else if (bus.dsp_ready) begin
                bus.dsp_valid <= 1'b0;
            end
        end
    end
    release_of_clear_register: assert property (@(posedge clk) disable iff (reset)
        rel |-> inuse[bus.cmt_wid][bus.cmt_rd]);
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb_scoreboard_hazard_unit: directed and random issue/commit traffic checked against a register-set model
module tb_scoreboard_hazard_unit;
    localparam int NW = 4, NR = 64, NT = 4, XL = 32, UB = 44;
    typedef struct packed {
        logic [UB-1:0] uuid;
        logic [1:0]    wid;
        logic [NT-1:0] tmask;
        logic [XL-1:0] pc;
        logic          wb;
        logic [5:0]    rd, rs1, rs2, rs3;
    } instr_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    scoreboard_hazard_unit_if #(.NUM_WARPS(NW), .NUM_REGS(NR), .NUM_THREADS(NT), .XLEN(XL), .UUID_BITS(UB)) bus ();
    scoreboard_hazard_unit #(.NUM_WARPS(NW), .NUM_REGS(NR), .NUM_THREADS(NT), .XLEN(XL), .UUID_BITS(UB)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    instr_t      prog[$];
    instr_t      expq[$];
    logic [7:0]  live[$];
    bit          inflight [NW][NR];
    int          pi = 0;
    bit          mdv = 1'b0;
    int unsigned mstall = 0;
    int          checks = 0, failures = 0;
    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask
    function automatic instr_t mk(int w, bit wb, int rd, int rs1, int rs2, int rs3);
        instr_t x;
        x.uuid = {$urandom, $urandom};
        x.wid = 2'(w);
        x.tmask = 4'($urandom);
        x.pc = $urandom;
        x.wb = wb;
        x.rd = 6'(rd);
        x.rs1 = 6'(rs1);
        x.rs2 = 6'(rs2);
        x.rs3 = 6'(rs3);
        return x;
    endfunction
    // a register blocks while it has an uncommitted writer, unless that writer commits now
    function automatic bit rb(logic [1:0] w, logic [5:0] r, bit rel, logic [1:0] cw, logic [5:0] cr);
        return r != 0 && inflight[w][r] && !(rel && cw == w && cr == r);
    endfunction
    function automatic instr_t cur_instr(int k);
        return k < prog.size() ? prog[k] : '0;
    endfunction
    task automatic drive_cur(instr_t c, instr_t nx);
        bus.sb_uuid = c.uuid;
        bus.sb_wid = c.wid;
        bus.sb_tmask = c.tmask;
        bus.sb_PC = c.pc;
        bus.sb_wb = c.wb;
        bus.sb_rd = c.rd;
        bus.sb_rd_n = nx.rd;
        bus.sb_rs1_n = nx.rs1;
        bus.sb_rs2_n = nx.rs2;
        bus.sb_rs3_n = nx.rs3;
        bus.sb_wid_n = nx.wid;
    endtask
    task automatic cycle(bit v, bit dr, bit cv, logic [1:0] cw, logic [5:0] crd, bit cwb, bit ceop);
        instr_t c;
        bit rel, hz, rdy, fire;
        @(negedge clk);
        c = cur_instr(pi);
        v = v && (pi < prog.size());
        rel = cv && cwb && ceop && crd != 0;
        hz = v && (rb(c.wid, c.rd, rel, cw, crd) || rb(c.wid, c.rs1, rel, cw, crd) ||
                   rb(c.wid, c.rs2, rel, cw, crd) || rb(c.wid, c.rs3, rel, cw, crd));
        rdy = !hz && (!mdv || dr);
        fire = v && rdy;
        bus.sb_valid = v;
        bus.dsp_ready = dr;
        bus.cmt_valid = cv;
        bus.cmt_wid = cw;
        bus.cmt_rd = crd;
        bus.cmt_wb = cwb;
        bus.cmt_eop = ceop;
        drive_cur(c, fire ? cur_instr(pi + 1) : c);
        #1;
        chk("sb_ready", bus.sb_ready, rdy);
        chk("dsp_valid", bus.dsp_valid, mdv);
        chk("perf_stalls", bus.perf_stalls, mstall);
        if (hz && mstall != 32'hffff_ffff) mstall++;
        if (rel) begin
            inflight[cw][crd] = 1'b0;
            for (int k = 0; k < live.size(); k++)
                if (live[k] == {cw, crd}) begin
                    live.delete(k);
                    break;
                end
        end
        if (fire) begin
            expq.push_back(c);
            if (c.wb && c.rd != 0) begin
                inflight[c.wid][c.rd] = 1'b1;
                live.push_back({c.wid, c.rd});
            end
            pi++;
        end
        mdv = fire ? 1'b1 : dr ? 1'b0 : mdv;
    endtask
    task automatic idle_cycle(bit dr);
        cycle(1'b1, dr, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0);
    endtask
    task automatic commit(logic [1:0] w, logic [5:0] r, bit eop);
        cycle(1'b1, 1'b1, 1'b1, w, r, 1'b1, eop);
    endtask
    task automatic drain();
        logic [7:0] e;
        int n;
        for (n = 0; n < 400 && !(pi >= prog.size() && live.size() == 0 && expq.size() == 0); n++) begin
            if (live.size() > 0) begin
                e = live[0];
                commit(e[7:6], e[5:0], 1'b1);
            end else idle_cycle(1'b1);
        end
        chk("drain_bounded", n < 400, 1);
    endtask
    task automatic do_reset();
        instr_t c;
        @(negedge clk);
        c = cur_instr(pi);
        reset = 1'b1;
        bus.sb_valid = pi < prog.size();
        bus.dsp_ready = 1'b0;
        bus.cmt_valid = 1'b0;
        drive_cur(c, c);
        #1;
        chk("ready_in_reset", bus.sb_ready, 0);
        expq.delete();
        live.delete();
        inflight = '{default: '0};
        mdv = 1'b0;
        mstall = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_dsp_valid", bus.dsp_valid, 0);
        chk("reset_perf_stalls", bus.perf_stalls, 0);
        chk("reset_dsp_uuid", bus.dsp_uuid, 0);
    endtask
    initial begin : monitor
        instr_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && bus.dsp_valid && bus.dsp_ready) begin
                if (expq.size() == 0) chk("dsp_unexpected", bus.dsp_valid, 0);
                else begin
                    e = expq.pop_front();
                    chk("dsp_uuid", bus.dsp_uuid, e.uuid);
                    chk("dsp_fields", {bus.dsp_wid, bus.dsp_tmask, bus.dsp_PC, bus.dsp_wb, bus.dsp_rd},
                        {e.wid, e.tmask, e.pc, e.wb, e.rd});
                end
            end
        end
    end
    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end
    initial begin : stim
        int p0;
        int unsigned s0;
        instr_t x;
        logic [7:0] e;
        bus.sb_valid = 0;
        bus.dsp_ready = 0;
        bus.cmt_valid = 0;
        bus.cmt_wid = 0;
        bus.cmt_rd = 0;
        bus.cmt_wb = 0;
        bus.cmt_eop = 0;
        drive_cur('0, '0);
        repeat (2) @(posedge clk);
        do_reset();
        // independent stream
        p0 = pi;
        for (int r = 1; r <= 8; r++) prog.push_back(mk(0, 1, r, 0, 0, 0));
        repeat (8) idle_cycle(1'b1);
        chk("indep_fires", pi - p0, 8);
        idle_cycle(1'b1);
        chk("indep_stalls", bus.perf_stalls, 0);
        drain();
        // RAW held until the commit
        s0 = mstall;
        p0 = pi;
        prog.push_back(mk(1, 1, 5, 0, 0, 0));
        prog.push_back(mk(1, 1, 6, 0, 5, 0));
        repeat (4) idle_cycle(1'b1);
        chk("raw_held", pi - p0, 1);
        commit(2'd1, 6'd5, 1'b1);
        chk("raw_released", pi - p0, 2);
        idle_cycle(1'b1);
        chk("raw_stalls", bus.perf_stalls, s0 + 3);
        drain();
        // cross-warp isolation
        s0 = mstall;
        p0 = pi;
        prog.push_back(mk(0, 1, 5, 0, 0, 0));
        prog.push_back(mk(2, 1, 9, 5, 0, 0));
        repeat (2) idle_cycle(1'b1);
        chk("xwarp_fires", pi - p0, 2);
        idle_cycle(1'b1);
        chk("xwarp_stalls", bus.perf_stalls, s0);
        drain();
        // same-cycle reserve and release
        p0 = pi;
        prog.push_back(mk(0, 1, 3, 0, 0, 0));
        prog.push_back(mk(0, 1, 3, 1, 0, 0));
        prog.push_back(mk(0, 1, 4, 3, 0, 0));
        repeat (2) idle_cycle(1'b1);
        commit(2'd0, 6'd3, 1'b1);
        chk("rr_fired", pi - p0, 2);
        chk("rr_inuse", dut.inuse[0][3], 1);
        idle_cycle(1'b1);
        commit(2'd0, 6'd3, 1'b1);
        drain();
        // multi-packet commit and r0
        p0 = pi;
        prog.push_back(mk(3, 1, 7, 0, 0, 0));
        prog.push_back(mk(3, 1, 8, 0, 0, 7));
        prog.push_back(mk(3, 1, 0, 0, 0, 0));
        prog.push_back(mk(3, 1, 0, 0, 0, 0));
        idle_cycle(1'b1);
        commit(2'd3, 6'd7, 1'b0);
        chk("eop0_held", pi - p0, 1);
        commit(2'd3, 6'd7, 1'b1);
        repeat (2) idle_cycle(1'b1);
        chk("r0_flow", pi - p0, 4);
        drain();
        // backpressure then reset mid-stall
        p0 = pi;
        x = mk(1, 1, 10, 0, 0, 0);
        prog.push_back(x);
        prog.push_back(mk(1, 1, 11, 0, 0, 0));
        prog.push_back(mk(1, 1, 12, 0, 0, 0));
        idle_cycle(1'b0);
        for (int k = 0; k < 5; k++) begin
            idle_cycle(1'b0);
            chk("bp_hold_uuid", bus.dsp_uuid, x.uuid);
            chk("bp_hold_pc", bus.dsp_PC, x.pc);
        end
        chk("bp_one_fire", pi - p0, 1);
        do_reset();
        for (int w = 0; w < NW; w++) chk("reset_inuse", dut.inuse[w], 0);
        drain();
        // random traffic
        for (int k = 0; k < 700; k++)
            prog.push_back(mk($urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 3) == 0 ? $urandom_range(0, 63) : 0));
        for (int n = 0; n < 6000 && pi < prog.size(); n++) begin
            if (live.size() > 0 && $urandom_range(0, 99) < 40) begin
                e = live[$urandom_range(0, live.size() - 1)];
                cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 1'b1, e[7:6], e[5:0],
                    $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
            end else
                cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 1'b0, 2'($urandom),
                    6'($urandom), 1'($urandom), 1'($urandom));
        end
        chk("random_consumed", pi == prog.size(), 1);
        drain();
        repeat (3) idle_cycle(1'b1);
        chk("expq_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scoreboard_hazard_unit.md
# scoreboard_hazard_unit

Per-warp register scoreboard between the instruction buffer and dispatch. It accepts instructions over the scoreboard handshake and tracks every in-flight destination register per warp. Instructions with a RAW or WAW hazard are held until the hazard clears; the rest are forwarded through a one-entry output register. Destination reservations are released by the writeback commit port.

## Interface
- NUM_WARPS, 4, warp count; NW_BITS = max(1, clog2(NUM_WARPS))
- NUM_REGS, 64, architectural registers per warp (int + fp); NR_BITS = clog2(NUM_REGS)
- NUM_THREADS, 4, tmask width
- XLEN, 32, PC width
- UUID_BITS, 44, trace id width (min 1)
- clk  in  1  clock
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- sb_valid / sb_uuid / sb_wid / sb_tmask / sb_PC / sb_wb / sb_rd  in  1/UUID_BITS/NW_BITS/NUM_THREADS/XLEN/1/NR_BITS  current instruction
- sb_rd_n / sb_rs1_n / sb_rs2_n / sb_rs3_n / sb_wid_n  in  NR_BITS×4/NW_BITS  registers of the instruction presented next cycle
- sb_ready  out  1  accept current instruction
- dsp_valid / dsp_uuid / dsp_wid / dsp_tmask / dsp_PC / dsp_wb / dsp_rd  out  same widths  registered issue to dispatch
- dsp_ready  in  1  dispatch accepts
- cmt_valid  in  1  writeback packet
- cmt_wid  in  NW_BITS
- cmt_rd  in  NR_BITS
- cmt_wb  in  1
- cmt_eop  in  1  last packet of instruction
- perf_stalls  out  32  saturating hazard-stall cycle count

## Operation
- State: inuse[NUM_WARPS][NUM_REGS] bits; lookahead regs op_reg[4] (rd, rs1, rs2, rs3) and op_wid; op_busy[4]; output register.
- Lookahead contract: the *_n fields at cycle t describe the instruction on sb_* at t+1. When there is no fire at t, the *_n fields equal the current instruction's fields.
- Every cycle: op_reg ← {rd_n, rs1_n, rs2_n, rs3_n}, op_wid ← wid_n.
- op_busy[i] ← next-state inuse[wid_n][reg_i]. Next state includes this cycle's reserve and release.
- Register 0 is never reserved or busy.
- Current-cycle correction: busy_i = op_busy[i] & ~(release this cycle to (op_wid, op_reg[i])).
- hazard = sb_valid & |busy.
- out_free = ~dsp_valid | dsp_ready.
- sb_ready = ~hazard & out_free.
- fire = sb_valid & sb_ready.
- Reserve: on fire, if sb_wb and sb_rd≠0, set inuse[sb_wid][sb_rd].
- Release: if cmt_valid & cmt_wb & cmt_eop and cmt_rd≠0, clear inuse[cmt_wid][cmt_rd].
- Same (wid,rd) reserved and released in one cycle: the reserve wins and the bit ends set.
- Releasing a clear bit is a no-op. A simulation assertion flags it.
- Output register: on fire, capture sb_* and set dsp_valid. Else if dsp_ready, clear dsp_valid. dsp_* is held stable while dsp_valid & ~dsp_ready.
- perf_stalls increments each cycle with sb_valid & hazard. It saturates at 2^32−1.
- Reset: inuse all 0, op_busy 0, dsp_valid 0, dsp_* payload 0, perf_stalls 0.
- sb_ready is combinational and is 0 while reset is asserted.
- Reset mid-operation drops all reservations and any held dsp entry.

## Timing
- Latency: fire at cycle t gives dsp_valid at t+1.
- Throughput: 1 instruction/cycle with no hazards and dsp_ready held high.
- Back-to-back dependence: instruction B reads rd of A, and A fires at t. B is presented at t+1 and sees busy, because the reservation is forwarded into op_busy.
- Release at cycle t unblocks a waiting instruction in cycle t itself, through the combinational correction. Commit-to-issue is 0 cycles.
- Release at t for the instruction presented at t+1 is folded into op_busy at t.
- No combinational path from dsp_ready to dsp_*. The only path from dsp_ready to sb_ready is through out_free.

## Test plan
- Independent stream: warp 0, 8 instructions with rd=1..8, rs=0, dsp_ready=1 → 8 dsp beats on consecutive cycles, each 1 cycle after its fire, perf_stalls=0.
- RAW: A writes r5 (w1), B reads rs2=r5 (w1) next; commit r5 at cycle 10 → B held until cycle 10. B fires at 10 and appears on dsp at 11. perf_stalls equals the stall cycle count.
- Cross-warp isolation: A writes r5 in w0, B reads r5 in w2 → B fires the cycle after A with no stall.
- Same-cycle reserve/release: r3 of w0 is in flight. A new w0 instruction writes r3 while commit w0/r3/eop arrives in the same cycle → it fires that cycle, and inuse[0][3] stays 1. A later commit clears it.
- Multi-packet commit and r0: commit r7 with eop=0 → still busy. eop=1 → released. An instruction with rd=0, wb=1 never blocks a reader of r0.
- Backpressure/reset: dsp_ready=0 for 5 cycles → dsp payload stable, sb_ready=0 after the first capture. Assert reset mid-stall → next cycle dsp_valid=0, inuse clear, perf_stalls=0.
